fpga_config_loader: RTL

- Next-generation configuration loader. Walks the binary config image in ROM/flash once per start: reads the header, validates it, then streams every connection record into an on-chip connection table.
- Downstream RDMA/switch logic reads the table through a 1-cycle lookup port; no per-query memory traffic.
- Adds over the previous reader: variable-latency memory handshake, per-read timeout, count bound check, error codes and an up-link counter.

---
 rtl/fpga_config_loader_if.sv | 20 ++
 rtl/fpga_config_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_config_loader_if.sv
// Memory read port between the configuration loader (master) and ROM/flash (slave).
// One request at a time: mem_rd_en pulses with mem_addr, data returns on mem_rd_valid.
interface fpga_config_loader_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd_valid;
   logic [31:0]           mem_rd_data;

   modport master (
      output mem_rd_en, mem_addr,
      input  mem_rd_valid, mem_rd_data
   );

   modport slave (
      input  mem_rd_en, mem_addr,
      output mem_rd_valid, mem_rd_data
   );
endinterface

// File: rtl/fpga_config_loader.sv
// Configuration loader: reads the image header from memory, validates it and
// streams every connection record into an on-chip table with a registered
// lookup port for the downstream RDMA/switch logic.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | nothing loaded since reset
// HDR_REQ   | issue read of header word k
// HDR_WAIT  | wait for header word k (timed)
// CHECK     | validate magic and connection count
// CONN_REQ  | issue read of word k of record n
// CONN_WAIT | wait for record word k (timed)
// COMMIT    | write record n into the table
// DONE      | image loaded, table valid
// ERROR     | load failed, error_code holds the reason
module fpga_config_loader #(
   parameter int                  MAX_CONNECTIONS = 64,
   parameter int                  ADDR_WIDTH      = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
   parameter logic [31:0]         MAGIC           = 32'h41544746,
   parameter int                  WORDS_PER_CONN  = 11,
   parameter int                  TIMEOUT_CYCLES  = 1024,
   localparam int                 IDX_W           = $clog2(MAX_CONNECTIONS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [1:0]          error_code,
   output logic [IDX_W:0]      conn_count,
   output logic [IDX_W:0]      num_up,
   output logic [31:0]         hdr_version,
   output logic [31:0]         hdr_timestamp,
   fpga_config_loader_if.master mem,
   input  logic                lk_en,
   input  logic [IDX_W-1:0]    lk_index,
   output logic                lk_valid,
   output logic                lk_hit,
   output logic [31:0]         lk_switch_id,
   output logic [31:0]         lk_host_id,
   output logic [31:0]         lk_my_ip,
   output logic [31:0]         lk_peer_ip,
   output logic [15:0]         lk_my_port,
   output logic [15:0]         lk_peer_port,
   output logic [15:0]         lk_my_qp,
   output logic [15:0]         lk_peer_qp,
   output logic [47:0]         lk_my_mac,
   output logic [47:0]         lk_peer_mac,
   output logic                lk_up
);

   localparam int KW = $clog2(WORDS_PER_CONN);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   // WAIT spans TIMEOUT_CYCLES-1 cycles so the error lands exactly TIMEOUT_CYCLES after rd_en
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 2);
   localparam logic [KW-1:0] K_HDR_LAST  = KW'(3);
   localparam logic [KW-1:0] K_CONN_LAST = KW'(WORDS_PER_CONN - 1);
   localparam logic [KW-1:0] K_UP        = KW'(9);

   typedef enum logic [3:0] {
      IDLE, HDR_REQ, HDR_WAIT, CHECK, CONN_REQ, CONN_WAIT, COMMIT, DONE, ERROR
   } state_t;

   typedef struct packed {
      logic [31:0] switch_id;
      logic [31:0] host_id;
      logic [31:0] my_ip;
      logic [31:0] peer_ip;
      logic [15:0] my_port;
      logic [15:0] peer_port;
      logic [15:0] my_qp;
      logic [15:0] peer_qp;
      logic [47:0] my_mac;
      logic [47:0] peer_mac;
      logic        up;
   } conn_rec_t;

   state_t                state, state_nxt;
   logic [KW-1:0]         k;
   logic [IDX_W-1:0]      n;
   logic [IDX_W:0]        n_inc;
   logic [IDX_W:0]        cnt_total;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [TW-1:0]         tmo_cnt;
   logic                  tmo_zero;
   logic                  last_rec;
   logic                  rd_en;
   logic [31:0]           hdr_buf [0:3];
   logic [31:0]           rec_buf [0:8];
   logic                  rec_up;
   conn_rec_t             rec_new;
   conn_rec_t             lk_rec;
   conn_rec_t             conn_tab [MAX_CONNECTIONS];
   logic                  hit_nxt;

   assign n_inc    = {1'b0, n} + (IDX_W+1)'(1);
   assign last_rec = (n_inc == cnt_total);
   assign tmo_zero = (tmo_cnt == '0);

   assign mem.mem_rd_en = rd_en;
   assign mem.mem_addr  = rd_en ? rd_addr : '0;

   // Record field extraction; MAC bytes arrive little-endian within each word
   always_comb begin
      rec_new           = '0;
      rec_new.switch_id = rec_buf[0];
      rec_new.host_id   = rec_buf[1];
      rec_new.my_ip     = rec_buf[2];
      rec_new.peer_ip   = rec_buf[3];
      rec_new.my_port   = rec_buf[4][15:0];
      rec_new.peer_port = rec_buf[4][31:16];
      rec_new.my_qp     = rec_buf[5][15:0];
      rec_new.peer_qp   = rec_buf[5][31:16];
      rec_new.my_mac    = {rec_buf[6][7:0], rec_buf[6][15:8], rec_buf[6][23:16],
                           rec_buf[6][31:24], rec_buf[7][7:0], rec_buf[7][15:8]};
      rec_new.peer_mac  = {rec_buf[7][23:16], rec_buf[7][31:24], rec_buf[8][7:0],
                           rec_buf[8][15:8], rec_buf[8][23:16], rec_buf[8][31:24]};
      rec_new.up        = rec_up;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode and state-derived outputs
   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      error     = 1'b0;
      case (state)
         IDLE, DONE, ERROR: begin
            busy  = 1'b0;
            done  = (state == DONE);
            error = (state == ERROR);
            if (start) state_nxt = HDR_REQ;
         end
         HDR_REQ: begin
            rd_en     = 1'b1;
            state_nxt = HDR_WAIT;
         end
         HDR_WAIT: begin
            if (mem.mem_rd_valid) state_nxt = (k == K_HDR_LAST) ? CHECK : HDR_REQ;
            else if (tmo_zero)    state_nxt = ERROR;
         end
         CHECK: begin
            if (hdr_buf[0] != MAGIC)                      state_nxt = ERROR;
            else if (hdr_buf[2] > 32'(MAX_CONNECTIONS))   state_nxt = ERROR;
            else if (hdr_buf[2] == 32'd0)                 state_nxt = DONE;
            else                                          state_nxt = CONN_REQ;
         end
         CONN_REQ: begin
            rd_en     = 1'b1;
            state_nxt = CONN_WAIT;
         end
         CONN_WAIT: begin
            if (mem.mem_rd_valid) state_nxt = (k == K_CONN_LAST) ? COMMIT : CONN_REQ;
            else if (tmo_zero)    state_nxt = ERROR;
         end
         COMMIT: begin
            state_nxt = last_rec ? DONE : CONN_REQ;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Load datapath: read address, word/record counters, timeout, header and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k             <= '0;
         n             <= '0;
         cnt_total     <= '0;
         rd_addr       <= '0;
         tmo_cnt       <= '0;
         rec_up        <= 1'b0;
         error_code    <= 2'd0;
         conn_count    <= '0;
         num_up        <= '0;
         hdr_version   <= '0;
         hdr_timestamp <= '0;
         for (int i = 0; i < 4; i++) hdr_buf[i] <= '0;
         for (int i = 0; i < 9; i++) rec_buf[i] <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  k          <= '0;
                  n          <= '0;
                  rd_addr    <= BASE_ADDR;
                  error_code <= 2'd0;
                  conn_count <= '0;
                  num_up     <= '0;
               end
            end
            HDR_REQ, CONN_REQ: tmo_cnt <= TMO_LOAD;
            HDR_WAIT: begin
               if (mem.mem_rd_valid) begin
                  hdr_buf[k[1:0]] <= mem.mem_rd_data;
                  rd_addr         <= rd_addr + ADDR_WIDTH'(4);
                  k               <= (k == K_HDR_LAST) ? '0 : k + KW'(1);
               end else if (tmo_zero) begin
                  error_code <= 2'd3;
               end else begin
                  tmo_cnt <= tmo_cnt - TW'(1);
               end
            end
            CHECK: begin
               hdr_version   <= hdr_buf[1];
               hdr_timestamp <= hdr_buf[3];
               cnt_total     <= hdr_buf[2][IDX_W:0];
               if (hdr_buf[0] != MAGIC)                    error_code <= 2'd1;
               else if (hdr_buf[2] > 32'(MAX_CONNECTIONS)) error_code <= 2'd2;
            end
            CONN_WAIT: begin
               if (mem.mem_rd_valid) begin
                  if (k == K_UP)     rec_up <= (mem.mem_rd_data[7:0] != 8'd0);
                  else if (k < K_UP) rec_buf[4'(k)] <= mem.mem_rd_data;
                  rd_addr <= rd_addr + ADDR_WIDTH'(4);
                  k       <= (k == K_CONN_LAST) ? '0 : k + KW'(1);
               end else if (tmo_zero) begin
                  error_code <= 2'd3;
               end else begin
                  tmo_cnt <= tmo_cnt - TW'(1);
               end
            end
            COMMIT: begin
               conn_count <= n_inc;
               num_up     <= num_up + (IDX_W+1)'(rec_up);
               n          <= n + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Connection table; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (state == COMMIT) conn_tab[n] <= rec_new;
   end

   assign hit_nxt = lk_en && done && ({1'b0, lk_index} < conn_count);

   // Registered lookup; misses return all-zero fields
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lk_valid <= 1'b0;
         lk_hit   <= 1'b0;
         lk_rec   <= '0;
      end else begin
         lk_valid <= lk_en;
         lk_hit   <= hit_nxt;
         lk_rec   <= hit_nxt ? conn_tab[lk_index] : '0;
      end
   end

   assign lk_switch_id = lk_rec.switch_id;
   assign lk_host_id   = lk_rec.host_id;
   assign lk_my_ip     = lk_rec.my_ip;
   assign lk_peer_ip   = lk_rec.peer_ip;
   assign lk_my_port   = lk_rec.my_port;
   assign lk_peer_port = lk_rec.peer_port;
   assign lk_my_qp     = lk_rec.my_qp;
   assign lk_peer_qp   = lk_rec.peer_qp;
   assign lk_my_mac    = lk_rec.my_mac;
   assign lk_peer_mac  = lk_rec.peer_mac;
   assign lk_up        = lk_rec.up;

endmodule
